fpaddsub_execute_pipe: RTL and testbench
========================================

Name: fpaddsub_execute_pipe

Overview:
Parametrised, pipelined mantissa add/subtract execute stage for the FP adder/subtractor datapath. It sits between alignment and normalisation. It accepts an aligned operand pair (larger mantissa Mmax, shifted smaller mantissa Mmin with its guard/sticky bits) plus the sign/op controls. It produces the raw magnitude sum/difference, result sign and residual guard/sticky bits. It has a valid/ready handshake and configurable pipeline depth with full backpressure.

Parameters:
MW, 24, fraction width; mantissa inputs are MW+1 bits (hidden bit included), Sum is MW+2 bits.
STAGES, 2, pipeline register stages, legal range 1..4; latency equals STAGES when not stalled.

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand set valid
in_ready  output  1  stage 0 can accept this cycle
Mmax  input  MW+1  larger-magnitude aligned mantissa
Mmin  input  MW+1  smaller aligned mantissa
G  input  1  guard bit shifted out of Mmin
S  input  1  sticky bit shifted out of Mmin
Sa  input  1  sign of operand A
Sb  input  1  sign of operand B
MaxAB  input  1  1 = B has larger magnitude
OpMode  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
Sum  output  MW+2  magnitude result (carry bit at MSB)
GSo  output  2  residual guard/sticky after operation
Sgn  output  1  result sign
Zero  output  1  Sum==0 and GSo==0

Behaviour:
- Effective op: Op = OpMode ^ Sa ^ Sb; Op=1 is magnitude subtract.
- Extended operands: X = {1'b0, Mmax, 2'b00}, Y = {1'b0, Mmin, G, S}, both MW+4 bits. R = Op ? X - Y : X + Y. Sum = R[MW+3:2], GSo = R[1:0].
- Precondition: Mmax >= Mmin. If it is violated, R wraps modulo 2^(MW+4). No flag is raised.
- Sgn = MaxAB ? (Sb ^ OpMode) : Sa. Zero = (R == 0). Sgn is not forced positive on zero; the rounding stage owns that.
- Arithmetic is computed combinationally in front of stage 0. Stages 1..STAGES-1 are pure retiming registers holding {Sum, GSo, Sgn, Zero}.
- Each stage k has a valid bit v[k]. Stage k loads when its upstream is valid and (v[k]==0 or stage k advances). The last stage advances when out_ready=1. Bubbles collapse, so a non-full pipe accepts input even when out_ready=0.
- in_ready = ~v[0] | stage-0-advances. It is combinational from out_ready through the chain; the ready path is not registered.
- Transfer in occurs on in_valid & in_ready. Transfer out occurs on out_valid & out_ready.
- Simultaneous in/out transfer with a full pipe: the pipe shifts and occupancy is unchanged.
- out_valid = v[STAGES-1]. Output data are held stable while out_valid=1 and out_ready=0.
- Reset: all v[] = 0, out_valid = 0, Sum = 0, GSo = 0, Sgn = 0, Zero = 0. Reset asserted mid-operation discards all in-flight results immediately. No transfer occurs on the first edge after deassertion unless in_valid=1.
- Throughput: one result per cycle when out_ready is held at 1.

Optional Feature:
FPADDSUB_EXEC_LZC_EN
- When defined: adds output port Lzc [$clog2(MW+2):0]. It is the leading-zero count of Sum, computed in front of stage 0 and pipelined alongside Sum. Sum==0 gives Lzc = MW+2. Normalisation can then skip its own counter.
- When undefined: no Lzc port and no LZC logic. All other behaviour is identical.

Decomposition:
- Shared package fpaddsub_pkg holds:
  - MW default constant
  - the stage payload struct {Sum, GSo, Sgn, Zero[, Lzc]}
  - the Op encoding constants (ADD=0, SUB=1)
- One sub-module, fpaddsub_exec_lzc: a parametrised priority leading-zero counter, instantiated only under FPADDSUB_EXEC_LZC_EN.

Test Plan:
1. Add: Mmax=0x1000000, Mmin=0x0800000, Sa=Sb=OpMode=0, G=S=0 -> after 2 cycles Sum=0x1800000, GSo=0, Sgn=0, Zero=0.
2. Subtract with guard borrow: Mmax=0x1000000, Mmin=0x0800000, OpMode=1, G=1, S=0 -> Sum=0x07FFFFF, GSo=2'b10. With G=0: Sum=0x0800000, GSo=0.
3. Sign mix: Mmax=0x1000000, Mmin=0x0400000, Sa=0, Sb=1, OpMode=0, MaxAB=0 -> Sum=0x0C00000, Sgn=0. MaxAB=1 -> Sgn=1. Carry case Mmax=Mmin=0x1FFFFFF add -> Sum=0x3FFFFFE.
4. Backpressure: stream 6 vectors with out_ready=0 -> in_ready drops after exactly STAGES accepts. Release out_ready -> 6 results appear in order, none lost or duplicated, outputs stable while stalled.
5. Zero / reset: Mmax=Mmin=0x1000000 subtract -> Zero=1, Sum=0. Assert rst_n=0 with 2 results in flight -> out_valid=0 and outputs 0 asynchronously, nothing emitted after release.
6. With FPADDSUB_EXEC_LZC_EN: Sum=0x0800000 -> Lzc=2; Sum=0 -> Lzc=26. Sweep STAGES=1 and 4, checking latency of 1 and 4 cycles.

Source files
------------

// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the FP add/subtract datapath.
//   MW_DEFAULT      default fraction width (mantissas are MW+1 bits with hidden bit)
//   LZC_W_DEFAULT   leading-zero count width for the default MW
//   OP_ADD/OP_SUB   effective-operation encoding
//   exec_payload_t  execute-stage result record at the default width
// Optional feature macro: FPADDSUB_EXEC_LZC_EN adds the lzc field to the payload.
package fpaddsub_pkg;

    localparam int unsigned MW_DEFAULT    = 24;
    localparam int unsigned LZC_W_DEFAULT = $clog2(MW_DEFAULT + 2) + 1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Field order matches the per-stage register layout in fpaddsub_execute_pipe.
    typedef struct packed {
        logic [MW_DEFAULT+1:0]    sum;
        logic [1:0]               gso;
        logic                     sgn;
        logic                     zero;
`ifdef FPADDSUB_EXEC_LZC_EN
        logic [LZC_W_DEFAULT-1:0] lzc;
`endif
    } exec_payload_t;

endpackage

// File: rtl/fpaddsub_exec_lzc.sv
// Priority leading-zero counter.
//   value  input  WIDTH  word to scan from the MSB down
//   count  output CNT_W  number of leading zeros; WIDTH when value is zero
// Only instantiated when FPADDSUB_EXEC_LZC_EN is defined.
module fpaddsub_exec_lzc
    import fpaddsub_pkg::*;
#(
    parameter int unsigned WIDTH = MW_DEFAULT + 2,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scanning upward, the last set bit seen is the most significant one.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (value[i]) begin
                count = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_execute_pipe.sv
// Pipelined mantissa add/subtract execute stage (between alignment and normalisation).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready combinational from out_ready)
//   Mmax, Mmin            aligned mantissas, MW+1 bits, Mmax >= Mmin expected
//   G, S                  guard/sticky shifted out of Mmin
//   Sa, Sb, MaxAB, OpMode operand signs, larger-operand select, 0=add 1=sub
//   out_valid / out_ready result handshake
//   Sum                   MW+2-bit magnitude (carry at MSB)
//   GSo                   residual guard/sticky
//   Sgn                   result sign (not forced positive on zero)
//   Zero                  Sum==0 and GSo==0
//   Lzc                   leading zeros of Sum (only with FPADDSUB_EXEC_LZC_EN)
// Parameters: MW fraction width, STAGES register stages (legal 1..4) = latency.
// Optional feature macro: FPADDSUB_EXEC_LZC_EN.
module fpaddsub_execute_pipe
    import fpaddsub_pkg::*;
#(
    parameter int unsigned MW     = MW_DEFAULT,
    parameter int unsigned STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW:0]   Mmax,
    input  logic [MW:0]   Mmin,
    input  logic          G,
    input  logic          S,
    input  logic          Sa,
    input  logic          Sb,
    input  logic          MaxAB,
    input  logic          OpMode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW+1:0] Sum,
    output logic [1:0]    GSo,
    output logic          Sgn,
    output logic          Zero
`ifdef FPADDSUB_EXEC_LZC_EN
    ,
    output logic [$clog2(MW+2):0] Lzc
`endif
);

    localparam int unsigned RW = MW + 4;
    localparam int unsigned LW = $clog2(MW + 2) + 1;

    // Same field order as fpaddsub_pkg::exec_payload_t, sized by MW.
    typedef struct packed {
        logic [MW+1:0] sum;
        logic [1:0]    gso;
        logic          sgn;
        logic          zero;
`ifdef FPADDSUB_EXEC_LZC_EN
        logic [LW-1:0] lzc;
`endif
    } payload_t;

    // ------------------------------------------------------------------
    // Arithmetic in front of stage 0
    // ------------------------------------------------------------------
    logic          op_eff;
    logic [RW-1:0] ext_max;
    logic [RW-1:0] ext_min;
    logic [RW-1:0] r;
    logic [MW+1:0] sum_raw;
    payload_t      stage_in;

    always_comb begin
        op_eff  = OpMode ^ Sa ^ Sb;
        ext_max = {1'b0, Mmax, 2'b00};
        ext_min = {1'b0, Mmin, G, S};
        // Wraps modulo 2^RW if Mmax < Mmin; callers guarantee ordering.
        r       = (op_eff == OP_SUB) ? (ext_max - ext_min) : (ext_max + ext_min);
    end

    assign sum_raw = r[RW-1:2];

`ifdef FPADDSUB_EXEC_LZC_EN
    logic [LW-1:0] lzc_raw;

    fpaddsub_exec_lzc #(
        .WIDTH (MW + 2),
        .CNT_W (LW)
    ) u_lzc (
        .value (sum_raw),
        .count (lzc_raw)
    );
`endif

    always_comb begin
        stage_in.sum  = sum_raw;
        stage_in.gso  = r[1:0];
        // B larger: its effective sign flips when subtracting.
        stage_in.sgn  = MaxAB ? (Sb ^ OpMode) : Sa;
        stage_in.zero = (r == '0);
`ifdef FPADDSUB_EXEC_LZC_EN
        stage_in.lzc  = lzc_raw;
`endif
    end

    // ------------------------------------------------------------------
    // Elastic register chain with collapsing bubbles
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    payload_t          data_q  [STAGES];
    payload_t          up_data [STAGES];

    always_comb begin : ctrl
        logic tail_full;
        tail_full = 1'b1;
        adv       = '0;
        load      = '0;
        v_d       = v_q;
        // A stage is blocked only when it and every stage after it are full
        // and the sink is not taking; this flattens the ready chain.
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            tail_full = tail_full & v_q[k];
            adv[k]    = v_q[k] & ~(tail_full & ~out_ready);
        end
        load[0] = in_valid & (~v_q[0] | adv[0]);
        for (int k = 1; k < int'(STAGES); k++) begin
            load[k] = adv[k-1];
        end
        for (int k = 0; k < int'(STAGES); k++) begin
            v_d[k] = load[k] | (v_q[k] & ~adv[k]);
        end
    end

    always_comb begin
        up_data[0] = stage_in;
        for (int k = 1; k < int'(STAGES); k++) begin
            up_data[k] = data_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    data_q[k] <= up_data[k];
                end
            end
        end
    end

    assign in_ready  = ~v_q[0] | adv[0];
    assign out_valid = v_q[STAGES-1];
    assign Sum       = data_q[STAGES-1].sum;
    assign GSo       = data_q[STAGES-1].gso;
    assign Sgn       = data_q[STAGES-1].sgn;
    assign Zero      = data_q[STAGES-1].zero;
`ifdef FPADDSUB_EXEC_LZC_EN
    assign Lzc       = data_q[STAGES-1].lzc;
`endif

endmodule

// File: tb/tb_fpaddsub_execute_pipe.sv
// Self-checking bench for fpaddsub_execute_pipe (main instance STAGES=2, plus
// STAGES=1 and STAGES=4 instances sharing the inputs for latency checks).
module tb_fpaddsub_execute_pipe;

    localparam int MW  = 24;
    localparam int STG = 2;
    localparam int LW  = $clog2(MW + 2) + 1;

    typedef struct {
        logic [MW:0] mmax;
        logic [MW:0] mmin;
        logic        g, s, sa, sb, maxab, opmode;
    } in_t;

    typedef struct {
        logic [MW+1:0] sum;
        logic [1:0]    gso;
        logic          sgn;
        logic          zero;
        int            lzc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic          clk, rst_n, in_valid, out_ready;
    logic [MW:0]   mmax, mmin;
    logic          g, s, sa, sb, maxab, opmode;
    logic          in_ready, out_valid, sgn, zero;
    logic          in_ready1, out_valid1, sgn1, zero1;
    logic          in_ready4, out_valid4, sgn4, zero4;
    logic [MW+1:0] sum, sum1, sum4;
    logic [1:0]    gso, gso1, gso4;
`ifdef FPADDSUB_EXEC_LZC_EN
    logic [LW-1:0] lzc, lzc1, lzc4;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpaddsub_execute_pipe #(.MW(MW), .STAGES(STG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Mmax(mmax), .Mmin(mmin), .G(g), .S(s), .Sa(sa), .Sb(sb), .MaxAB(maxab),
        .OpMode(opmode), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(sum), .GSo(gso), .Sgn(sgn), .Zero(zero)
`ifdef FPADDSUB_EXEC_LZC_EN
        , .Lzc(lzc)
`endif
    );

    fpaddsub_execute_pipe #(.MW(MW), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .Mmax(mmax), .Mmin(mmin), .G(g), .S(s), .Sa(sa), .Sb(sb), .MaxAB(maxab),
        .OpMode(opmode), .out_valid(out_valid1), .out_ready(out_ready),
        .Sum(sum1), .GSo(gso1), .Sgn(sgn1), .Zero(zero1)
`ifdef FPADDSUB_EXEC_LZC_EN
        , .Lzc(lzc1)
`endif
    );

    fpaddsub_execute_pipe #(.MW(MW), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .Mmax(mmax), .Mmin(mmin), .G(g), .S(s), .Sa(sa), .Sb(sb), .MaxAB(maxab),
        .OpMode(opmode), .out_valid(out_valid4), .out_ready(out_ready),
        .Sum(sum4), .GSo(gso4), .Sgn(sgn4), .Zero(zero4)
`ifdef FPADDSUB_EXEC_LZC_EN
        , .Lzc(lzc4)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t q[$];
    in_t  cur;
    bit   prev_stall = 1'b0;
    logic [MW+1:0] prev_sum;
    logic [1:0]    prev_gso;
    logic          prev_sgn, prev_zero;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: textbook signed-magnitude add/sub on mantissas scaled by 4 so
    // guard/sticky sit in the two fractional bits.
    function automatic exp_t model(input in_t v);
        exp_t   e;
        longint x, y, r;
        bit     do_sub;
        x      = longint'(v.mmax) * 4;
        y      = longint'(v.mmin) * 4 + longint'(v.g) * 2 + longint'(v.s);
        do_sub = (v.sa == v.sb) ? v.opmode : !v.opmode;
        r      = do_sub ? x - y : x + y;
        if (r < 0) r += longint'(1) << (MW + 4);
        e.sum  = (MW+2)'(r / 4);
        e.gso  = 2'(r % 4);
        e.zero = (r == 0);
        e.sgn  = v.maxab ? (v.opmode ? !v.sb : v.sb) : v.sa;
        e.lzc  = (MW + 2) - $clog2(r / 4 + 1);
        return e;
    endfunction

    function automatic in_t mk_in(logic [MW:0] mx, logic [MW:0] mn, logic g_, logic s_,
                                  logic sa_, logic sb_, logic mab, logic op);
        in_t v;
        v.mmax = mx; v.mmin = mn; v.g = g_; v.s = s_;
        v.sa = sa_; v.sb = sb_; v.maxab = mab; v.opmode = op;
        return v;
    endfunction

    function automatic exp_t mk_exp(logic [MW+1:0] es, logic [1:0] eg, logic esg, logic ez,
                                    int el);
        exp_t e;
        e.sum = es; e.gso = eg; e.sgn = esg; e.zero = ez; e.lzc = el;
        return e;
    endfunction

    function automatic in_t rnd_in();
        in_t v;
        v.mmax = {1'b1, 24'($urandom)};
        if ($urandom_range(0, 7) == 0)      v.mmin = v.mmax;
        else if ($urandom_range(0, 9) == 0) v.mmin = 25'($urandom);
        else                                v.mmin = v.mmax >> $urandom_range(0, 25);
        v.g = 1'($urandom); v.s = 1'($urandom); v.sa = 1'($urandom);
        v.sb = 1'($urandom); v.maxab = 1'($urandom); v.opmode = 1'($urandom);
        return v;
    endfunction

    task automatic drive(input in_t v);
        mmax = v.mmax; mmin = v.mmin; g = v.g; s = v.s;
        sa = v.sa; sb = v.sb; maxab = v.maxab; opmode = v.opmode;
    endtask

    // One cycle on the main instance: called at posedge+1 with in_valid/out_ready/cur set.
    task automatic tick(output bit acc);
        exp_t e;
        drive(cur);
        #1;
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, prev_sum);
            chk("hold_gso", gso, prev_gso);
            chk("hold_sgn", sgn, prev_sgn);
            chk("hold_zero", zero, prev_zero);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out actual=valid required=no_result_pending");
            end else begin
                e = q.pop_front();
                chk("out_sum", sum, e.sum);
                chk("out_gso", gso, e.gso);
                chk("out_sgn", sgn, e.sgn);
                chk("out_zero", zero, e.zero);
`ifdef FPADDSUB_EXEC_LZC_EN
                chk("out_lzc", lzc, e.lzc);
`endif
                n_out++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(cur));
        prev_stall = out_valid && !out_ready;
        prev_sum = sum; prev_gso = gso; prev_sgn = sgn; prev_zero = zero;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_dir(input vec_t v, input int idx);
        int l1, l2, l4;
        cur = v.i;
        drive(cur);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("dir%0d_in_ready", idx), {in_ready, in_ready1, in_ready4}, 3'b111);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l1 = 0; l2 = 0; l4 = 0;
        for (int n = 1; n <= 8; n++) begin
            if (out_valid && l2 == 0) begin
                l2 = n;
                chk($sformatf("dir%0d_sum", idx), sum, v.e.sum);
                chk($sformatf("dir%0d_gso", idx), gso, v.e.gso);
                chk($sformatf("dir%0d_sgn", idx), sgn, v.e.sgn);
                chk($sformatf("dir%0d_zero", idx), zero, v.e.zero);
`ifdef FPADDSUB_EXEC_LZC_EN
                chk($sformatf("dir%0d_lzc", idx), lzc, v.e.lzc);
`endif
            end
            if (out_valid1 && l1 == 0) begin
                l1 = n;
                chk($sformatf("dir%0d_s1_res", idx), {sum1, gso1, sgn1, zero1},
                    {v.e.sum, v.e.gso, v.e.sgn, v.e.zero});
`ifdef FPADDSUB_EXEC_LZC_EN
                chk($sformatf("dir%0d_s1_lzc", idx), lzc1, v.e.lzc);
`endif
            end
            if (out_valid4 && l4 == 0) begin
                l4 = n;
                chk($sformatf("dir%0d_s4_res", idx), {sum4, gso4, sgn4, zero4},
                    {v.e.sum, v.e.gso, v.e.sgn, v.e.zero});
`ifdef FPADDSUB_EXEC_LZC_EN
                chk($sformatf("dir%0d_s4_lzc", idx), lzc4, v.e.lzc);
`endif
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("dir%0d_latency_s2", idx), l2, STG);
        chk($sformatf("dir%0d_latency_s1", idx), l1, 1);
        chk($sformatf("dir%0d_latency_s4", idx), l4, 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int idx, cnt;
        bit need_new;
        in_t bp[6];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cur       = mk_in(0, 0, 0, 0, 0, 0, 0, 0);
        drive(cur);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", {sum, gso, sgn, zero}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_first_edge", {out_valid, out_valid1, out_valid4}, 3'b000);

        // Directed vectors: {Mmax, Mmin, G, S, Sa, Sb, MaxAB, OpMode} -> {Sum, GSo, Sgn, Zero, Lzc}
        tbl[0].i  = mk_in(25'h1000000, 25'h0800000, 0, 0, 0, 0, 0, 0);
        tbl[0].e  = mk_exp(26'h1800000, 2'b00, 0, 0, 1);
        tbl[1].i  = mk_in(25'h1000000, 25'h0800000, 1, 0, 0, 0, 0, 1);
        tbl[1].e  = mk_exp(26'h07FFFFF, 2'b10, 0, 0, 3);
        tbl[2].i  = mk_in(25'h1000000, 25'h0800000, 0, 0, 0, 0, 0, 1);
        tbl[2].e  = mk_exp(26'h0800000, 2'b00, 0, 0, 2);
        tbl[3].i  = mk_in(25'h1000000, 25'h0400000, 0, 0, 0, 1, 0, 0);
        tbl[3].e  = mk_exp(26'h0C00000, 2'b00, 0, 0, 2);
        tbl[4].i  = mk_in(25'h1000000, 25'h0400000, 0, 0, 0, 1, 1, 0);
        tbl[4].e  = mk_exp(26'h0C00000, 2'b00, 1, 0, 2);
        tbl[5].i  = mk_in(25'h1FFFFFF, 25'h1FFFFFF, 0, 0, 0, 0, 0, 0);
        tbl[5].e  = mk_exp(26'h3FFFFFE, 2'b00, 0, 0, 0);
        tbl[6].i  = mk_in(25'h1000000, 25'h1000000, 0, 0, 0, 0, 0, 1);
        tbl[6].e  = mk_exp(26'h0000000, 2'b00, 0, 1, 26);
        tbl[7].i  = mk_in(25'h1000000, 25'h1000000, 0, 0, 1, 0, 0, 0);
        tbl[7].e  = mk_exp(26'h0000000, 2'b00, 1, 1, 26);
        tbl[8].i  = mk_in(25'h0000100, 25'h0000100, 0, 1, 0, 0, 0, 1);
        tbl[8].e  = mk_exp(26'h3FFFFFF, 2'b11, 0, 0, 0);
        tbl[9].i  = mk_in(25'h1000000, 25'h0000001, 1, 1, 1, 1, 1, 1);
        tbl[9].e  = mk_exp(26'h0FFFFFE, 2'b01, 0, 0, 2);
        tbl[10].i = mk_in(25'h0000003, 25'h0000001, 1, 1, 0, 0, 0, 0);
        tbl[10].e = mk_exp(26'h0000004, 2'b11, 0, 0, 23);
        for (int i = 0; i < 11; i++) apply_dir(tbl[i], i);

        // Full-rate streaming: one accept per cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cur = rnd_in();
            tick(acc);
            if (acc) cnt++;
        end
        chk("throughput_accepts", cnt, 20);

        // Backpressure: out_ready low, six vectors offered.
        for (int i = 0; i < 6; i++) bp[i] = rnd_in();
        in_valid = 1'b0;
        for (int i = 0; i < 6 && q.size() > 0; i++) tick(acc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            cur = bp[idx];
            tick(acc);
            if (acc) idx++;
        end
        chk("bp_accepts_when_stalled", idx, STG);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        cnt = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (idx < 6 || q.size() > 0); c++) begin
            in_valid = (idx < 6);
            if (idx < 6) cur = bp[idx];
            tick(acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 6);
        chk("bp_results_out", n_out - cnt, 6);

        // Random traffic against the reference model.
        need_new = 1'b1;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            if (need_new) cur = rnd_in();
            tick(acc);
            need_new = acc;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) tick(acc);
        chk("rand_drained", q.size(), 0);
        chk("rand_idle_valid", out_valid, 0);

        // Reset with two results in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx = 0;
        for (int c = 0; c < 5 && idx < 2; c++) begin
            cur = rnd_in();
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("prerst_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {out_valid, out_valid4}, 0);
        chk("async_rst_out", {sum, gso, sgn, zero}, 0);
        chk("async_rst_in_ready", in_ready, 1);
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", {out_valid, out_valid1, out_valid4}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
